// File: rtl/pet_spi_pkg.sv
// Shared definitions for the Pi-facing SPI command decoder: opcodes, FSM
// states and the bus address width.
package pet_spi_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OP_WRITE_AT   = 2'b00,
    OP_READ_AT    = 2'b01,
    OP_WRITE_NEXT = 2'b10,
    OP_READ_NEXT  = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_CMD     = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_DATA    = 3'd3,
    ST_ISSUE   = 3'd4,
    ST_DISCARD = 3'd5
  } state_e;

  // Writes are the even opcodes; reads the odd ones.
  function automatic logic op_is_write(input opcode_e op);
    return (op == OP_WRITE_AT) || (op == OP_WRITE_NEXT);
  endfunction

  // Address post-increment; the register width gives the 1FFFF -> 00000 wrap.
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/spi_cmd.sv
// Decodes command bytes received from the Pi into single bus read/write
// requests, with an auto-incrementing address for the _NEXT opcodes.
module spi_cmd
  import pet_spi_pkg::*;
(
  input  logic              clk_bus_i,
  input  logic              reset_i,
  input  logic              spi_start_i,
  input  logic [DATA_W-1:0] spi_rx_byte_i,
  input  logic              spi_rx_valid_i,
  output logic [ADDR_W-1:0] spi_addr_o,
  output logic [DATA_W-1:0] spi_data_o,
  output logic              spi_wr_en_o,
  output logic              spi_rd_en_o,
  input  logic              spi_done_i,
  input  logic [DATA_W-1:0] spi_rd_data_i,
  output logic [DATA_W-1:0] spi_tx_byte_o,
  output logic              spi_err_o
);

  state_e              state_q;
  opcode_e             op_q;
  opcode_e             rx_op;
  logic                addr16_q;
  logic [DATA_W-1:0]   addr_hi_q;
  logic [DATA_W-1:0]   addr_lo_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   tx_q;
  logic                wr_en_q;
  logic                rd_en_q;
  logic                err_q;
  logic                req_active;

  assign rx_op      = opcode_e'(spi_rx_byte_i[7:6]);
  assign req_active = wr_en_q | rd_en_q;

  // Operand bytes are staged in addr16/addr_hi/addr_lo and only committed to
  // the live address and data registers when ISSUE is entered, so a frame
  // restart mid-command leaves the previous address untouched.
  always_ff @(posedge clk_bus_i) begin
    if (reset_i) begin
      state_q   <= ST_CMD;
      op_q      <= OP_WRITE_AT;
      addr16_q  <= 1'b0;
      addr_hi_q <= '0;
      addr_lo_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      tx_q      <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      err_q     <= 1'b0;
    end else if (state_q == ST_ISSUE) begin
      if (spi_rx_valid_i && !spi_start_i) begin
        err_q <= 1'b1;
      end
      if (!req_active) begin
        wr_en_q <= op_is_write(op_q);
        rd_en_q <= !op_is_write(op_q);
      end else if (spi_done_i) begin
        wr_en_q <= 1'b0;
        rd_en_q <= 1'b0;
        addr_q  <= addr_next(addr_q);
        if (rd_en_q) begin
          tx_q <= spi_rd_data_i;
        end
        state_q <= ST_CMD;
      end
    end else if (spi_start_i) begin
      state_q <= ST_CMD;
    end else if (spi_rx_valid_i) begin
      case (state_q)
        ST_CMD: begin
          op_q     <= rx_op;
          addr16_q <= spi_rx_byte_i[0];
          case (rx_op)
            OP_WRITE_AT,
            OP_READ_AT:    state_q <= ST_ADDR_HI;
            OP_WRITE_NEXT: state_q <= ST_DATA;
            OP_READ_NEXT:  state_q <= ST_ISSUE;
            default: begin
              state_q <= ST_DISCARD;
              err_q   <= 1'b1;
            end
          endcase
        end
        ST_ADDR_HI: begin
          addr_hi_q <= spi_rx_byte_i;
          state_q   <= ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          addr_lo_q <= spi_rx_byte_i;
          if (op_is_write(op_q)) begin
            state_q <= ST_DATA;
          end else begin
            addr_q  <= {addr16_q, addr_hi_q, spi_rx_byte_i};
            state_q <= ST_ISSUE;
          end
        end
        ST_DATA: begin
          data_q <= spi_rx_byte_i;
          if (op_q == OP_WRITE_AT) begin
            addr_q <= {addr16_q, addr_hi_q, addr_lo_q};
          end
          state_q <= ST_ISSUE;
        end
        default: ;
      endcase
    end
  end

  assign spi_addr_o    = addr_q;
  assign spi_data_o    = data_q;
  assign spi_wr_en_o   = wr_en_q;
  assign spi_rd_en_o   = rd_en_q;
  assign spi_tx_byte_o = tx_q;
  assign spi_err_o     = err_q;

endmodule

// File: tb/tb_spi_cmd.sv
// Directed bench for spi_cmd: expected bus requests are queued as commands are
// sent and compared when the decoder raises its request.
module tb_spi_cmd;

  logic        clk_bus_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        spi_start_i = 1'b0;
  logic [7:0]  spi_rx_byte_i = 8'h00;
  logic        spi_rx_valid_i = 1'b0;
  logic [16:0] spi_addr_o;
  logic [7:0]  spi_data_o;
  logic        spi_wr_en_o;
  logic        spi_rd_en_o;
  logic        spi_done_i = 1'b0;
  logic [7:0]  spi_rd_data_i = 8'h00;
  logic [7:0]  spi_tx_byte_o;
  logic        spi_err_o;

  typedef struct {
    logic        wr;
    logic [16:0] addr;
    logic [7:0]  data;
  } req_t;

  req_t sb[$];
  int   checks = 0;
  int   errors = 0;

  spi_cmd dut (
    .clk_bus_i     (clk_bus_i),
    .reset_i       (reset_i),
    .spi_start_i   (spi_start_i),
    .spi_rx_byte_i (spi_rx_byte_i),
    .spi_rx_valid_i(spi_rx_valid_i),
    .spi_addr_o    (spi_addr_o),
    .spi_data_o    (spi_data_o),
    .spi_wr_en_o   (spi_wr_en_o),
    .spi_rd_en_o   (spi_rd_en_o),
    .spi_done_i    (spi_done_i),
    .spi_rd_data_i (spi_rd_data_i),
    .spi_tx_byte_o (spi_tx_byte_o),
    .spi_err_o     (spi_err_o)
  );

  always #5 clk_bus_i = ~clk_bus_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [16:0] addr, input logic [7:0] data);
    req_t r;
    r.wr = wr;
    r.addr = addr;
    r.data = data;
    sb.push_back(r);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_bus_i);
    spi_rx_byte_i  = b;
    spi_rx_valid_i = 1'b1;
    @(negedge clk_bus_i);
    spi_rx_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk_bus_i);
    spi_start_i = 1'b1;
    @(negedge clk_bus_i);
    spi_start_i = 1'b0;
  endtask

  // Called right after the last command byte; the request must appear one cycle later.
  task automatic wait_req(input string tag);
    int   n;
    req_t e;
    n = 0;
    do begin
      @(negedge clk_bus_i);
      n++;
    end while (!(spi_wr_en_o || spi_rd_en_o) && n < 50);
    chk({tag, "_seen"}, 32'(spi_wr_en_o | spi_rd_en_o), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_wr_en"}, 32'(spi_wr_en_o), 32'(e.wr));
      chk({tag, "_rd_en"}, 32'(spi_rd_en_o), 32'(!e.wr));
      chk({tag, "_addr"}, 32'(spi_addr_o), 32'(e.addr));
      if (e.wr) chk({tag, "_data"}, 32'(spi_data_o), 32'(e.data));
    end
  endtask

  // Holds done low for a few cycles (request must stay put), then acknowledges.
  task automatic ack(input string tag, input logic [7:0] rd, input int hold);
    logic        wr0;
    logic [16:0] a0;
    logic [7:0]  d0;
    wr0 = spi_wr_en_o;
    a0  = spi_addr_o;
    d0  = spi_data_o;
    repeat (hold) @(negedge clk_bus_i);
    chk({tag, "_hold_wr"}, 32'(spi_wr_en_o), 32'(wr0));
    chk({tag, "_hold_rd"}, 32'(spi_rd_en_o), 32'(!wr0));
    chk({tag, "_hold_addr"}, 32'(spi_addr_o), 32'(a0));
    chk({tag, "_hold_data"}, 32'(spi_data_o), 32'(d0));
    spi_done_i    = 1'b1;
    spi_rd_data_i = rd;
    @(negedge clk_bus_i);
    spi_done_i    = 1'b0;
    spi_rd_data_i = 8'hE7;
    chk({tag, "_deassert"}, 32'({spi_wr_en_o, spi_rd_en_o}), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk_bus_i);
    chk("rst_addr", 32'(spi_addr_o), 32'd0);
    chk("rst_data", 32'(spi_data_o), 32'd0);
    chk("rst_en", 32'({spi_wr_en_o, spi_rd_en_o}), 32'd0);
    chk("rst_tx", 32'(spi_tx_byte_o), 32'd0);
    chk("rst_err", 32'(spi_err_o), 32'd0);
    reset_i = 1'b0;

    // WRITE_AT 1E80F <- 03
    pulse_start();
    push(1'b1, 17'h1E80F, 8'h03);
    send_byte(8'h01); send_byte(8'hE8); send_byte(8'h0F); send_byte(8'h03);
    wait_req("wr_at");
    ack("wr_at", 8'h00, 2);

    // READ_AT 08000, then READ_NEXT in the same frame
    pulse_start();
    push(1'b0, 17'h08000, 8'h00);
    send_byte(8'h40); send_byte(8'h80); send_byte(8'h00);
    wait_req("rd_at");
    ack("rd_at", 8'h5A, 1);
    chk("rd_at_tx", 32'(spi_tx_byte_o), 32'h5A);
    push(1'b0, 17'h08001, 8'h00);
    send_byte(8'hC0);
    wait_req("rd_next");
    ack("rd_next", 8'h77, 0);
    chk("rd_next_tx", 32'(spi_tx_byte_o), 32'h77);

    // Address wrap across WRITE_AT / WRITE_NEXT
    pulse_start();
    push(1'b1, 17'h1FFFF, 8'hAA);
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hAA);
    wait_req("wr_top");
    ack("wr_top", 8'h00, 1);
    push(1'b1, 17'h00000, 8'hBB);
    send_byte(8'h80); send_byte(8'hBB);
    wait_req("wr_wrap");
    ack("wr_wrap", 8'h00, 1);
    chk("wr_tx_hold", 32'(spi_tx_byte_o), 32'h77);
    chk("wr_no_err", 32'(spi_err_o), 32'd0);

    // Partial WRITE_AT abandoned by a frame restart
    pulse_start();
    send_byte(8'h00); send_byte(8'h12);
    pulse_start();
    push(1'b0, 17'h00001, 8'h00);
    send_byte(8'hC0);
    wait_req("abort");
    ack("abort", 8'h3C, 1);
    chk("abort_tx", 32'(spi_tx_byte_o), 32'h3C);
    chk("abort_no_err", 32'(spi_err_o), 32'd0);

    // Byte arriving while the request is outstanding
    pulse_start();
    push(1'b1, 17'h01020, 8'h99);
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h20); send_byte(8'h99);
    wait_req("overrun");
    send_byte(8'h55);
    chk("overrun_err", 32'(spi_err_o), 32'd1);
    chk("overrun_wr_held", 32'(spi_wr_en_o), 32'd1);
    ack("overrun", 8'h00, 1);
    push(1'b0, 17'h01021, 8'h00);
    send_byte(8'hC0);
    wait_req("overrun_next");
    ack("overrun_next", 8'h11, 1);
    chk("err_sticky", 32'(spi_err_o), 32'd1);

    // Reset while a request is outstanding
    pulse_start();
    push(1'b1, 17'h12345, 8'h67);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
    wait_req("mid_rst");
    reset_i = 1'b1;
    @(negedge clk_bus_i);
    reset_i = 1'b0;
    chk("mid_rst_en", 32'({spi_wr_en_o, spi_rd_en_o}), 32'd0);
    chk("mid_rst_addr", 32'(spi_addr_o), 32'd0);
    chk("mid_rst_data", 32'(spi_data_o), 32'd0);
    chk("mid_rst_tx", 32'(spi_tx_byte_o), 32'd0);
    chk("mid_rst_err", 32'(spi_err_o), 32'd0);
    pulse_start();
    push(1'b1, 17'h00005, 8'hEE);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h05); send_byte(8'hEE);
    wait_req("post_rst");
    ack("post_rst", 8'h00, 1);

    // Start and byte in the same cycle: the byte is dropped without error
    @(negedge clk_bus_i);
    spi_start_i    = 1'b1;
    spi_rx_valid_i = 1'b1;
    spi_rx_byte_i  = 8'h40;
    @(negedge clk_bus_i);
    spi_start_i    = 1'b0;
    spi_rx_valid_i = 1'b0;
    push(1'b0, 17'h00006, 8'h00);
    send_byte(8'hC0);
    wait_req("start_prio");
    ack("start_prio", 8'h42, 1);
    chk("start_prio_err", 32'(spi_err_o), 32'd0);
    chk("start_prio_tx", 32'(spi_tx_byte_o), 32'h42);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd.md
SPI_CMD -- requirements
Module: spi_cmd

Interface
REQ-001 SHALL have port clk_bus_i, input, 1 bit: the single bus clock; all logic is clocked on its rising edge.
REQ-002 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port spi_start_i, input, 1 bit: one-cycle strobe marking the start of an SPI frame (chip-select falling).
REQ-004 SHALL have port spi_rx_byte_i, input, 8 bits: deserialized byte received from the Pi; valid only when spi_rx_valid_i=1.
REQ-005 SHALL have port spi_rx_valid_i, input, 1 bit: one-cycle strobe per received byte.
REQ-006 SHALL have port spi_addr_o, output, 17 bits: bus address of the current request.
REQ-007 SHALL have port spi_data_o, output, 8 bits: write data of the current request.
REQ-008 SHALL have port spi_wr_en_o, output, 1 bit: write request, held until acknowledged.
REQ-009 SHALL have port spi_rd_en_o, output, 1 bit: read request, held until acknowledged.
REQ-010 SHALL have port spi_done_i, input, 1 bit: one-cycle acknowledge from the bus arbiter.
REQ-011 SHALL have port spi_rd_data_i, input, 8 bits: bus read data, valid in the spi_done_i cycle of a read.
REQ-012 SHALL have port spi_tx_byte_o, output, 8 bits: byte shifted back to the Pi (last read result).
REQ-013 SHALL have port spi_err_o, output, 1 bit: sticky flag for a bad opcode or an overrun.

Function
REQ-014 SHALL treat the first byte of each command as the command byte: bits[7:6] are the opcode and bit[0] is address bit 16.
REQ-015 SHALL implement these opcodes:
- 00 WRITE_AT: then addr[15:8], addr[7:0], data.
- 01 READ_AT: then addr[15:8], addr[7:0].
- 10 WRITE_NEXT: then data.
- 11 READ_NEXT: no operand bytes.
REQ-016 SHALL implement FSM states CMD, ADDR_HI, ADDR_LO, DATA, ISSUE, DISCARD; each transition out of CMD/ADDR_HI/ADDR_LO/DATA occurs only on a cycle with spi_rx_valid_i=1.
REQ-017 SHALL transition as follows:
- CMD -> ADDR_HI (the _AT opcodes), DATA (WRITE_NEXT), or ISSUE (READ_NEXT).
- ADDR_HI -> ADDR_LO.
- ADDR_LO -> DATA (write) or ISSUE (read).
- DATA -> ISSUE.
REQ-018 SHALL assert spi_wr_en_o or spi_rd_en_o in the cycle after entering ISSUE, and hold it, with spi_addr_o and spi_data_o stable, through the cycle in which spi_done_i=1; it deasserts the following cycle and the FSM returns to CMD.
REQ-019 SHALL never assert spi_wr_en_o and spi_rd_en_o simultaneously; spi_done_i outside ISSUE SHALL be ignored.
REQ-020 SHALL, on a read acknowledge, load spi_rd_data_i into spi_tx_byte_o in the spi_done_i cycle; spi_tx_byte_o holds otherwise.
REQ-021 SHALL increment the 17-bit address register by 1 after every acknowledged access, wrapping from 1FFFF to 00000; _AT opcodes load it and _NEXT opcodes use it.
REQ-022 SHALL accept multiple commands per frame, returning to CMD after each access.
REQ-023 SHALL, on spi_start_i in any state other than ISSUE, enter CMD the next cycle and discard any partial command.
REQ-024 SHALL, on spi_start_i during ISSUE, complete the outstanding request and then enter CMD.
REQ-025 SHALL drop any byte arriving while in ISSUE and set spi_err_o.
REQ-026 SHALL give spi_start_i priority over spi_rx_valid_i when both occur in the same cycle (the byte is dropped, spi_err_o is not set).
REQ-027 SHALL, on an undefined command, enter DISCARD, set spi_err_o, and ignore bytes until spi_start_i; with a 2-bit opcode all codes are defined, so DISCARD is reserved for future opcodes.
REQ-028 SHALL clear spi_err_o only on reset_i.

Reset
REQ-029 SHALL, while reset_i=1 at a clock edge, set state=CMD, address=0, spi_addr_o=0, spi_data_o=0, spi_wr_en_o=0, spi_rd_en_o=0, spi_tx_byte_o=0, spi_err_o=0.
REQ-030 SHALL abandon an in-flight request when reset_i is asserted mid-ISSUE; the request deasserts after that edge.

Structure
REQ-031 SHALL take the opcode enum, the FSM state enum and the 17-bit address width constant from shared package pet_spi_pkg.
REQ-032 SHALL be a single module with no sub-modules; the address counter is inline.

Verification
REQ-033 SHALL cover: WRITE_AT bytes 01,E8,0F,03 -> spi_wr_en_o=1, spi_addr_o=1E80F, spi_data_o=03 until spi_done_i, then deasserted.
REQ-034 SHALL cover: READ_AT 40,80,00 with spi_rd_data_i=5A at done -> spi_rd_en_o=1, spi_addr_o=08000, then spi_tx_byte_o=5A; READ_NEXT C0 -> spi_addr_o=08001.
REQ-035 SHALL cover: WRITE_AT 01,FF,FF,AA, then WRITE_NEXT 80,BB in the same frame -> writes to 1FFFF then 00000 (wrap).
REQ-036 SHALL cover: WRITE_AT 00,12 followed by spi_start_i, then READ_NEXT C0 -> no write issued; a read at the prior address.
REQ-037 SHALL cover: a byte sent while spi_done_i is held low in ISSUE -> the byte is dropped, spi_err_o=1, the request is still completed.
REQ-038 SHALL cover: reset_i pulsed mid-ISSUE -> all outputs 0 the next cycle; a subsequent WRITE_AT works normally.
